// File: rtl/split_add_serial.sv
// rtl/split_add_serial.sv - chunk-serial extending adder, valid/ready on both sides, one op in flight
// Defining SPLIT_ADD_SERIAL_CARRY_EN adds the sum_carry output (carry out of the last chunk).
module split_add_serial #(
  parameter int OP_W    = 7,
  parameter int SUM_W   = 13,
  parameter int CHUNK_W = 3,
  parameter int SIGNED  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op0,
  input  logic [OP_W-1:0]  op1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum0
`ifdef SPLIT_ADD_SERIAL_CARRY_EN
  ,
  output logic             sum_carry
`endif
);
  localparam int NCH    = (SUM_W + CHUNK_W - 1) / CHUNK_W;
  localparam int LAST_W = SUM_W - (NCH - 1) * CHUNK_W;
  localparam int KW     = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [KW-1:0]      idx;
  logic [SUM_W-1:0]   opa, opb, ext0, ext1, sum_nxt;
  logic [CHUNK_W-1:0] a_ch, b_ch;
  logic [CHUNK_W:0]   ch_sum;
  logic               carry, chunk_co, last_chunk, capture;

  assign last_chunk = (idx == KW'(NCH - 1));
  assign capture    = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by reset_n so it reads 0 while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = reset_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (SIGNED != 0) begin
      ext0 = SUM_W'($signed(op0));
      ext1 = SUM_W'($signed(op1));
    end else begin
      ext0 = SUM_W'(op0);
      ext1 = SUM_W'(op1);
    end
  end

  // Bits past SUM_W in the last chunk read as zero, so the carry lands at bit LAST_W
  always_comb begin
    a_ch    = '0;
    b_ch    = '0;
    sum_nxt = sum0;
    for (int j = 0; j < CHUNK_W; j++) begin
      if (int'(idx) * CHUNK_W + j < SUM_W) begin
        a_ch[j] = opa[int'(idx) * CHUNK_W + j];
        b_ch[j] = opb[int'(idx) * CHUNK_W + j];
      end
    end
    ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK_W{1'b0}}, carry};
    for (int j = 0; j < CHUNK_W; j++) begin
      if (int'(idx) * CHUNK_W + j < SUM_W) sum_nxt[int'(idx) * CHUNK_W + j] = ch_sum[j];
    end
    chunk_co = last_chunk ? ch_sum[LAST_W] : ch_sum[CHUNK_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa   <= '0;
      opb   <= '0;
      sum0  <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (capture) begin
      opa   <= ext0;
      opb   <= ext1;
      carry <= 1'b0;
      idx   <= '0;
    end else if (state == RUN) begin
      sum0  <= sum_nxt;
      carry <= chunk_co;
      if (!last_chunk) idx <= idx + KW'(1);
    end
  end

`ifdef SPLIT_ADD_SERIAL_CARRY_EN
  assign sum_carry = carry;
`endif

endmodule

// File: tb/tb_split_add_serial.sv
// tb/tb_split_add_serial.sv - scoreboard bench for split_add_serial over several chunk/sign configurations
// Compile with SPLIT_ADD_SERIAL_CARRY_EN defined to also check sum_carry.
module tb_split_add_serial;
  localparam int NI = 4;
  localparam int CWS[NI] = '{3, 1, 13, 13};
  localparam int SGS[NI] = '{1, 0, 1, 0};

  logic clk = 1'b0;
  logic reset_n;
  logic iv[NI], ir[NI], ov[NI], orr[NI];
  logic [6:0]  a0[NI], a1[NI];
  logic [12:0] s[NI];
  logic        sc[NI];
  int cyc = 0;
  int checks = 0, failures = 0;
  bit rand_ready = 1'b0;

  logic [12:0] exp_sum[NI][$];
  logic        exp_car[NI][$];
  int          exp_acc[NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, g, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    split_add_serial #(.OP_W(7), .SUM_W(13), .CHUNK_W(CWS[g]), .SIGNED(SGS[g])) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(iv[g]), .in_ready(ir[g]), .op0(a0[g]), .op1(a1[g]),
      .out_valid(ov[g]), .out_ready(orr[g]), .sum0(s[g])
`ifdef SPLIT_ADD_SERIAL_CARRY_EN
      , .sum_carry(sc[g])
`endif
    );
`ifndef SPLIT_ADD_SERIAL_CARRY_EN
    assign sc[g] = 1'b0;
`endif

    bit prev = 1'b0;
    always @(negedge clk) begin
      if (!reset_n) prev = 1'b0;
      else begin
        if (ov[g] && !prev) begin
          if (exp_acc[g].size() == 0) chk("spurious_out", g, 1, 0);
          else chk("latency", g, cyc - exp_acc[g][0], (13 + CWS[g] - 1) / CWS[g] + 1);
        end
        if (ov[g] && exp_sum[g].size() != 0) begin
          chk("sum0", g, s[g], exp_sum[g][0]);
          chk("in_ready_done", g, ir[g], 0);
`ifdef SPLIT_ADD_SERIAL_CARRY_EN
          chk("sum_carry", g, sc[g], exp_car[g][0]);
`endif
          if (orr[g]) begin
            exp_sum[g].delete(0);
            exp_car[g].delete(0);
            exp_acc[g].delete(0);
          end
        end
        prev = ov[g];
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) for (int g = 0; g < NI; g++) orr[g] = ($urandom_range(0, 3) != 0);
  end

  // Reference: extend to an integer, add, reduce mod 2^13; bit 13 is the carry
  task automatic model(input int g, input logic [6:0] x, input logic [6:0] y,
                       output logic [12:0] sm, output logic cr);
    int ex, ey, t;
    ex = (SGS[g] != 0) ? int'($signed(x)) : int'(x);
    ey = (SGS[g] != 0) ? int'($signed(y)) : int'(y);
    t  = (ex & 8191) + (ey & 8191);
    sm = t[12:0];
    cr = t[13];
  endtask

  task automatic issue(input int g, input logic [6:0] x, input logic [6:0] y);
    logic [12:0] sm;
    logic cr;
    int t = 0;
    @(negedge clk);
    a0[g] = x;
    a1[g] = y;
    iv[g] = 1'b1;
    while (!ir[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir[g]) chk("accept_timeout", g, 0, 1);
    else begin
      model(g, x, y, sm, cr);
      exp_sum[g].push_back(sm);
      exp_car[g].push_back(cr);
      exp_acc[g].push_back(cyc);
    end
    @(negedge clk);
    iv[g] = 1'b0;
    a0[g] = 7'($urandom);
    a1[g] = 7'($urandom);
  endtask

  task automatic wait_empty(input int bound);
    int t = 0;
    int pend;
    pend = 1;
    while (pend != 0 && t < bound) begin
      @(negedge clk);
      t++;
      pend = 0;
      for (int g = 0; g < NI; g++) pend += exp_sum[g].size();
    end
    chk("drain", -1, pend, 0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; orr[g] = 1'b1; a0[g] = '0; a1[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_in_ready", g, ir[g], 0);
      chk("rst_out_valid", g, ov[g], 0);
      chk("rst_sum0", g, s[g], 0);
      chk("rst_sum_carry", g, sc[g], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) chk("idle_in_ready", g, ir[g], 1);

    issue(0, 7'd2, 7'd5);
    issue(0, 7'h7F, 7'h7F);
    issue(0, 7'h40, 7'h40);
    issue(0, 7'd63, 7'd63);
    issue(3, 7'd127, 7'd127);
    issue(1, 7'd127, 7'd127);
    issue(2, 7'h7F, 7'h7F);
    wait_empty(200);

    // Held result: out_ready low for 10 cycles while in_valid pokes at it
    @(posedge clk); #1 orr[0] = 1'b0;
    issue(0, 7'd20, 7'h65);
    t = 0;
    while (!ov[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wait_valid", 0, ov[0], 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 0, ov[0], 1);
      iv[0] = 1'b1;
      a0[0] = 7'($urandom);
      a1[0] = 7'($urandom);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk); #1 orr[0] = 1'b1;
    issue(0, 7'h7B, 7'd9);
    wait_empty(200);

    // Reset while the third chunk is being added
    issue(0, 7'h55, 7'h2A);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun_rst_valid", 0, ov[0], 0);
    chk("midrun_rst_sum0", 0, s[0], 0);
    chk("midrun_rst_ready", 0, ir[0], 0);
    for (int g = 0; g < NI; g++) begin
      exp_sum[g].delete(); exp_car[g].delete(); exp_acc[g].delete();
    end
    @(negedge clk);
    reset_n = 1'b1;
    issue(0, 7'd3, 7'h7C);
    wait_empty(200);

    rand_ready = 1'b1;
    for (int g = 0; g < NI; g++) begin
      fork
        automatic int gg = g;
        repeat (40) issue(gg, 7'($urandom), 7'($urandom));
      join_none
    end
    wait fork;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) orr[g] = 1'b1;
    wait_empty(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
